// File: rtl/fc_classifier.sv
// Fully-connected output stage: one serial MAC computes every class score
// (bias + dot product) and tracks the argmax, under a start/done handshake.
module fc_classifier #(
  parameter int In_d_W  = 18,
  parameter int N_In    = 4,
  parameter int N_Class = 3,
  parameter int W_d_W   = 8,
  parameter int Acc_W   = 32,
  parameter int Cls_W   = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [N_In*In_d_W-1:0]        X,
  input  logic [N_Class*N_In*W_d_W-1:0] Wt,
  input  logic [N_Class*Acc_W-1:0]      B,
  output logic                          busy,
  output logic                          done,
  output logic [N_Class*Acc_W-1:0]      Z,
  output logic [Cls_W-1:0]              cls
);

  localparam int I_W = (N_In > 1) ? $clog2(N_In) : 1;
  localparam int P_W = In_d_W + W_d_W + 1;

  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;
  state_t state;

  logic        [In_d_W-1:0] x_r    [N_In];
  logic signed [W_d_W-1:0]  w_r    [N_Class][N_In];
  logic signed [Acc_W-1:0]  b_r    [N_Class];
  logic signed [Acc_W-1:0]  shadow [N_Class];

  logic        [I_W-1:0]   i;
  logic        [Cls_W-1:0] c;
  logic signed [Acc_W-1:0] acc;
  logic signed [Acc_W-1:0] best;
  logic        [Cls_W-1:0] best_idx;

  logic signed [In_d_W:0]  xs;
  logic signed [P_W-1:0]   prod;
  logic signed [Acc_W-1:0] term;
  logic signed [Acc_W-1:0] acc_next;
  logic                    last_i;
  logic                    last_c;
  logic                    better;

  // Features are unsigned, so a zero sign bit is prepended before the signed multiply.
  always_comb begin
    xs       = {1'b0, x_r[i]};
    prod     = xs * w_r[c][i];
    term     = {{(Acc_W-P_W){prod[P_W-1]}}, prod};
    acc_next = ((i == '0) ? b_r[c] : acc) + term;
    last_i   = (i == I_W'(N_In - 1));
    last_c   = (c == Cls_W'(N_Class - 1));
    better   = (c == '0) || (acc_next > best);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      Z        <= '0;
      cls      <= '0;
      i        <= '0;
      c        <= '0;
      acc      <= '0;
      best     <= '0;
      best_idx <= '0;
      for (int unsigned k = 0; k < N_Class; k++) begin
        shadow[k] <= '0;
        b_r[k]    <= '0;
        for (int unsigned j = 0; j < N_In; j++) w_r[k][j] <= '0;
      end
      for (int unsigned j = 0; j < N_In; j++) x_r[j] <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            for (int unsigned j = 0; j < N_In; j++)
              x_r[j] <= X[j*In_d_W +: In_d_W];
            for (int unsigned k = 0; k < N_Class; k++) begin
              b_r[k] <= B[k*Acc_W +: Acc_W];
              for (int unsigned j = 0; j < N_In; j++)
                w_r[k][j] <= Wt[(k*N_In+j)*W_d_W +: W_d_W];
            end
            i     <= '0;
            c     <= '0;
            busy  <= 1'b1;
            state <= MAC;
          end
        end
        MAC: begin
          acc <= acc_next;
          if (last_i) begin
            shadow[c] <= acc_next;
            if (better) begin
              best     <= acc_next;
              best_idx <= c;
            end
            i <= '0;
            c <= c + 1'b1;
            // Results are published on the edge that enters DONE, so the
            // final score and argmax bypass the shadow/best registers.
            if (last_c) begin
              for (int unsigned k = 0; k < N_Class; k++)
                Z[k*Acc_W +: Acc_W] <= (k == N_Class - 1) ? acc_next : shadow[k];
              cls   <= better ? c : best_idx;
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end
          end else begin
            i <= i + 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fc_classifier.sv
// Directed bench for fc_classifier: hand-computed scores, argmax ties,
// extremes, input latching, ignored start, mid-run reset, back-to-back runs.
module tb_fc_classifier;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [71:0] X;
  logic [95:0] Wt;
  logic [95:0] B;
  logic        busy;
  logic        done;
  logic [95:0] Z;
  logic [1:0]  cls;

  int checks = 0;
  int errors = 0;

  logic signed [31:0] prev_z0, prev_z1, prev_z2;
  logic        [1:0]  prev_cls;

  fc_classifier #(
    .In_d_W (18),
    .N_In   (4),
    .N_Class(3),
    .W_d_W  (8),
    .Acc_W  (32),
    .Cls_W  (2)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .X    (X),
    .Wt   (Wt),
    .B    (B),
    .busy (busy),
    .done (done),
    .Z    (Z),
    .cls  (cls)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_x(input int a0, input int a1, input int a2, input int a3);
    X = {a3[17:0], a2[17:0], a1[17:0], a0[17:0]};
  endtask

  task automatic set_row(input int row, input int w0, input int w1, input int w2, input int w3);
    Wt[(row*4+0)*8 +: 8] = w0[7:0];
    Wt[(row*4+1)*8 +: 8] = w1[7:0];
    Wt[(row*4+2)*8 +: 8] = w2[7:0];
    Wt[(row*4+3)*8 +: 8] = w3[7:0];
  endtask

  task automatic set_b(input int b0, input int b1, input int b2);
    B = {b2, b1, b0};
  endtask

  task automatic check_outputs(input string tag, input logic signed [31:0] e0,
                               input logic signed [31:0] e1, input logic signed [31:0] e2,
                               input logic [1:0] ec);
    check({tag, "_z0"}, Z[0 +: 32], e0);
    check({tag, "_z1"}, Z[32 +: 32], e1);
    check({tag, "_z2"}, Z[64 +: 32], e2);
    check({tag, "_cls"}, {30'd0, cls}, {30'd0, ec});
  endtask

  // mode 0: plain run; 1: disturb inputs and pulse start mid-run; 2: reset at cycle 6
  task automatic run(input string tag, input int mode,
                     input logic signed [31:0] e0, input logic signed [31:0] e1,
                     input logic signed [31:0] e2, input logic [1:0] ec);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      if (mode == 2 && k == 7) begin
        rst = 1'b0;
        check({tag, "_rst_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_rst_done"}, {31'd0, done}, 32'd0);
        check_outputs({tag, "_rst"}, 0, 0, 0, 2'd0);
        prev_z0 = 0; prev_z1 = 0; prev_z2 = 0; prev_cls = 2'd0;
        for (int n = 0; n < 15; n++) begin
          @(negedge clk);
          check({tag, "_nodone"}, {31'd0, done}, 32'd0);
        end
        return;
      end
      check({tag, "_busy"}, {31'd0, busy}, (k <= 12) ? 32'd1 : 32'd0);
      check({tag, "_done"}, {31'd0, done}, (k == 13) ? 32'd1 : 32'd0);
      if (k < 13) begin
        check_outputs({tag, "_hold"}, prev_z0, prev_z1, prev_z2, prev_cls);
      end else begin
        check_outputs(tag, e0, e1, e2, ec);
        prev_z0 = e0; prev_z1 = e1; prev_z2 = e2; prev_cls = ec;
      end
      if (mode == 1) begin
        if (k == 1) begin
          set_x(9, 9, 9, 9);
          set_row(0, 5, 5, 5, 5);
          set_row(1, 5, 5, 5, 5);
          set_row(2, 5, 5, 5, 5);
        end
        if (k == 5 || k == 13) start = 1'b1;
        if (k == 6) start = 1'b0;
      end
      if (mode == 2 && k == 6) rst = 1'b1;
    end
    @(negedge clk);
    start = 1'b0;
    check({tag, "_done_end"}, {31'd0, done}, 32'd0);
  endtask

  task automatic cfg_basic();
    set_x(1, 2, 3, 4);
    set_row(0, 1, 1, 1, 1);
    set_row(1, 0, 0, 0, 2);
    set_row(2, -1, -1, -1, -1);
    set_b(0, 0, 0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    X = '0; Wt = '0; B = '0;
    prev_z0 = 0; prev_z1 = 0; prev_z2 = 0; prev_cls = 2'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check_outputs("reset", 0, 0, 0, 2'd0);

    // Basic scores
    cfg_basic();
    run("basic", 0, 10, 8, -10, 2'd0);

    // Bias and ties
    set_row(0, 1, 1, 1, 1);
    set_row(1, 1, 1, 1, 1);
    set_row(2, 0, 0, 0, 0);
    set_b(0, 0, 10);
    run("tie", 0, 10, 10, 10, 2'd0);
    set_b(0, 1, 0);
    run("bias", 0, 10, 11, 0, 2'd1);

    // Extremes
    set_x(262143, 262143, 262143, 262143);
    set_row(0, -128, -128, -128, -128);
    set_row(1, -128, -128, -128, -128);
    set_row(2, -128, -128, -128, -128);
    set_b(0, 0, 0);
    run("ext_neg", 0, -134217216, -134217216, -134217216, 2'd0);
    set_row(0, 127, 127, 127, 127);
    set_row(1, 127, 127, 127, 127);
    set_row(2, 127, 127, 127, 127);
    set_b(0, 0, 1);
    run("ext_pos", 0, 133168644, 133168644, 133168645, 2'd2);

    // Input stability and ignored start
    cfg_basic();
    run("latch", 1, 10, 8, -10, 2'd0);
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      check("latch_idle_busy", {31'd0, busy}, 32'd0);
      check("latch_idle_done", {31'd0, done}, 32'd0);
    end

    // Reset mid-run, then a fresh run
    cfg_basic();
    run("midrst", 2, 0, 0, 0, 2'd0);
    set_b(0, 1, 0);
    set_row(0, 1, 1, 1, 1);
    set_row(1, 1, 1, 1, 1);
    set_row(2, 0, 0, 0, 0);
    run("after_rst", 0, 10, 11, 0, 2'd1);

    // Back-to-back runs
    cfg_basic();
    run("b2b_a", 0, 10, 8, -10, 2'd0);
    set_x(4, 3, 2, 1);
    run("b2b_b", 0, 10, 2, -10, 2'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fc_classifier.md
# fc_classifier

Fully-connected output stage that consumes the flattened pooled feature vector from the conv → ReLU → max-pool pipeline and produces per-class scores plus an argmax class index. One time-multiplexed MAC computes all class scores serially, one product per cycle, under a start/done handshake. It sits directly downstream of the CNN pipeline; its `X` input connects to that pipeline's pooled output bus.

## Interface

Parameters:
- `In_d_W`, 18: feature width. Features are unsigned (post-ReLU).
- `N_In`, 4: number of features (pooled rows × cols).
- `N_Class`, 3: number of output classes.
- `W_d_W`, 8: weight width, signed two's complement.
- `Acc_W`, 32: width of the bias, accumulator and score, all signed.
- `Cls_W`, 2: width of the class index. Must satisfy 2^Cls_W ≥ N_Class.

Ports:
- `clk`, in, 1: clock, rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `start`, in, 1: request one classification. Sampled only in IDLE.
- `X`, in, N_In*In_d_W: features. Feature i is at `X[i*In_d_W +: In_d_W]`.
- `Wt`, in, N_Class*N_In*W_d_W: weights. Weight (c,i) is at `Wt[(c*N_In+i)*W_d_W +: W_d_W]`.
- `B`, in, N_Class*Acc_W: biases. Bias c is at `B[c*Acc_W +: Acc_W]`.
- `busy`, out, 1: high from the cycle after `start` is accepted through the last MAC cycle.
- `done`, out, 1: one-cycle pulse when the results are updated.
- `Z`, out, N_Class*Acc_W: class scores. Score c is at `Z[c*Acc_W +: Acc_W]`.
- `cls`, out, Cls_W: index of the maximum score.

## Operation

- The FSM has three states: IDLE, MAC, DONE.
- **IDLE**
  - `busy`=0, `done`=0.
  - On `start`=1: latch `X`, `Wt` and `B` into internal registers, clear counters c=0 and i=0, and go to MAC.
  - Inputs may change after acceptance without affecting the run.
- **MAC** (one product per cycle, with i as the inner index)
  - term = zero-extend(X[i]) to In_d_W+1 bits, signed, multiplied by Wt[c][i], then sign-extended to Acc_W.
  - acc_next = (i==0 ? B[c] : acc) + term.
  - Arithmetic wraps modulo 2^Acc_W with no saturation. The default widths cannot overflow.
  - When i==N_In-1:
    - Write acc_next into shadow score c.
    - If c==0, or acc_next > best (signed, strict), then best ← acc_next and best_idx ← c. Ties therefore keep the lowest index.
    - Set i←0 and c←c+1.
  - Otherwise i←i+1.
  - After the product for c=N_Class-1, i=N_In-1, go to DONE.
- **DONE**
  - Lasts one cycle.
  - `Z` ← shadow scores, `cls` ← best_idx, `done`=1.
  - Go to IDLE.
- `Z` and `cls` change only on DONE entry. They hold their values until the next completion.
- `start` during MAC or DONE is ignored and is not queued.
- `rst` takes priority in any state. On reset:
  - FSM → IDLE.
  - `busy`=0, `done`=0, `Z`=0, `cls`=0.
  - Counters, acc, best and shadow scores are cleared.
  - An interrupted run produces no `done`.

## Timing

- Cycle 0 is the edge where `start` is sampled in IDLE.
- `busy` is high during cycles 1 .. N_Class*N_In. With defaults that is cycles 1–12.
- `done` is high in cycle N_Class*N_In+1 (13 with defaults). `Z` and `cls` are valid in that same cycle.
- The next `start` is accepted in cycle N_Class*N_In+2 at the earliest. Throughput is one result per N_Class*N_In+2 cycles.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan

All scenarios use default parameters.
1. **Basic scores.** X={1,2,3,4} (feature 0 = 1), W0={1,1,1,1}, W1={0,0,0,2}, W2={-1,-1,-1,-1}, B=0, one-cycle `start` → `done` in cycle 13, Z0=10, Z1=8, Z2=-10, `cls`=0; `busy` high for cycles 1–12 only.
2. **Bias and tie.** Same X, W0=W1={1,1,1,1}, W2=0, B={0,0,10} → Z={10,10,10}, `cls`=0 (lowest index wins). With B={0,1,0} → `cls`=1.
3. **Extreme values.** X all 262143, all weights -128, B=0 → every Z = -134217216 (no wrap), `cls`=0. Weights all +127, B2=1 → `cls`=2.
4. **Input stability and ignored start.** Change X and `Wt` on cycle 1, and pulse `start` on cycles 5 and 13 → results match the values latched at cycle 0, and exactly one `done`.
5. **Reset mid-run.** Assert `rst` at cycle 6 → the next cycle has `busy`=0, `Z`=0, `cls`=0, and no `done` follows. A fresh `start` afterwards gives the correct results at +13 cycles.
6. **Back-to-back runs.** Two runs with `start` at cycles 0 and 14 and different X → two `done` pulses at cycles 13 and 27. `Z` holds the first result during cycles 13–26.
